disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Time-multiplexed 4-digit 7-segment scan controller; sits directly upstream of the 4:1 × 5-bit digit mux.
- Drives the mux select (sel) and the four 5-bit mux data inputs (d0..d3) from a frame-coherent snapshot, plus active-low anode enables.
- Provides anti-ghosting blanking between digits, a per-digit enable mask, and a valid/ready update handshake so digit data changes only at frame boundaries.

Parameters:
ON_CYCLES, 50000, clk cycles a digit's anode is driven per slot (>=1)
BLANK_CYCLES, 1000, clk cycles all anodes are off between slots (0 = no blanking)
CNT_W, 16, counter width; must hold max(ON_CYCLES, BLANK_CYCLES)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous reset, active-low
enable  input  1  1 = scan, 0 = idle / display dark
dig_en  input  4  per-digit anode mask, bit i = digit i
upd_valid  input  1  producer has new digit data
upd_data  input  20  new digits, [4:0]=digit0 ... [19:15]=digit3
upd_ready  output  1  block accepts upd_data this cycle
sel  output  2  mux select, current digit slot
d0, d1, d2, d3  output  5 each  snapshot digit data to mux I0..I3
an_n  output  4  anode enables, active-low, one-hot-low or all 1
frame_start  output  1  one-cycle pulse on first DRIVE cycle of digit 0

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rstn).
- Reset values: state IDLE, counter 0, sel=0, d0..d3=0, an_n=4'b1111, frame_start=0. upd_ready is 1 during reset (IDLE).
- All outputs are registered except upd_ready, which is combinational from state/counter.
- IDLE:
  - an_n=1111, sel=0, counter held at 0.
  - upd_ready=1.
  - enable=1 -> DRIVE with sel=0; frame_start=1 in that first DRIVE cycle.
- DRIVE:
  - Lasts exactly ON_CYCLES cycles.
  - an_n[sel]=0 iff dig_en[sel]=1; all other bits 1.
  - dig_en is sampled every cycle, so a mask change takes effect next cycle.
  - After ON_CYCLES: -> BLANK if BLANK_CYCLES>0, else advance slot directly.
- BLANK:
  - an_n=1111 for exactly BLANK_CYCLES cycles, sel unchanged.
  - Then advance slot: sel <= sel+1 (3 wraps to 0) and enter DRIVE.
- Frame: 4 slots, period = 4*(ON_CYCLES+BLANK_CYCLES) cycles. Masked digits keep their slot time; the frame period is independent of dig_en.
- Frame boundary cycle: the final cycle of slot 3, i.e. the last BLANK cycle, or the last DRIVE cycle if BLANK_CYCLES=0.
- Update handshake:
  - upd_ready=1 in the frame boundary cycle and throughout IDLE; 0 otherwise.
  - Transfer occurs when upd_valid && upd_ready; d0..d3 <= upd_data slices on that clock edge.
  - New data is therefore visible from the first cycle of the next frame.
  - upd_valid without ready: no capture; the producer must hold valid and data until ready.
  - upd_valid may assert or deassert freely; there is no ready-depends-on-valid loop.
- frame_start pulses on every entry to DRIVE with sel=0, whether from IDLE or from a wrap.
- enable deasserted in any state:
  - Next cycle -> IDLE, an_n=1111, sel=0, counter=0.
  - d0..d3 retained.
  - A transfer in that same cycle still completes.
- enable re-asserted: restarts at digit 0 with a fresh frame_start.
- Reset mid-frame: immediate asynchronous return to reset values.
- Invariant: an_n never has more than one bit low, and never low in the same cycle sel changes. Sel changes only while an_n=1111 when BLANK_CYCLES>0.

Decomposition:
- Shared display package holds:
  - state encoding IDLE=2'd0, DRIVE=2'd1, BLANK=2'd2;
  - constants NUM_DIGITS=4, DIGIT_W=5.
- The cycle counter (load/clear/terminal-count flag) is a natural sub-module: slot_timer. Everything else stays in the top module.

Test Plan:
All with ON_CYCLES=4, BLANK_CYCLES=2 (frame = 24 cycles).
- Reset/idle: hold rstn=0, then release with enable=0 -> an_n=1111, sel=0, d0..d3=0, upd_ready=1 for 10 cycles.
- Scan sequence: enable=1, dig_en=1111:
  - an_n sequence is 1110 (4 cycles), 1111 (2), 1101 (4), 1111 (2), 1011 (4), 1111 (2), 0111 (4), 1111 (2), then repeats;
  - frame_start pulses every 24 cycles;
  - sel steps only during 1111.
- Update timing: mid-frame, assert upd_valid with upd_data=20'h8C631:
  - upd_ready rises only in the last BLANK cycle of slot 3;
  - next frame shows d0=5'h11, d1=5'h11, d2=5'h11, d3=5'h11;
  - d0..d3 unchanged before that edge.
- Mask: dig_en=0101 -> an_n is 1110 in slot 0, 1011 in slot 2, 1111 in slots 1 and 3; frame period still 24.
- Disable mid-slot: drop enable during slot 2 DRIVE -> next cycle an_n=1111, sel=0, d0..d3 retained. Re-enable -> frame_start pulses and digit 0 is driven first.
- BLANK_CYCLES=0 build -> no all-1111 gaps, frame = 16 cycles, upd_ready coincides with the last DRIVE cycle of slot 3.

Source files
------------

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller.
//   scan_state_e  : scan FSM encoding (IDLE / DRIVE / BLANK)
//   NUM_DIGITS    : digits per frame
//   DIGIT_W       : width of one digit code at the downstream mux
//   anode_pattern : active-low anode word for one slot under a digit mask
package disp_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  // One bit low (the slot's digit) when that digit is enabled, otherwise all off.
  function automatic logic [NUM_DIGITS-1:0] anode_pattern(
    input logic [1:0]            slot,
    input logic [NUM_DIGITS-1:0] mask
  );
    logic [NUM_DIGITS-1:0] an;
    an = '1;
    if (mask[slot]) an[slot] = 1'b0;
    return an;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_slot_timer.sv
// Slot cycle counter for the scan controller.
//   clk, rstn : clock, asynchronous active-low reset
//   clr_i     : force the count back to 0 on the next edge (otherwise count up)
//   term_i    : terminal count value for the current phase
//   tc_o      : high while the count equals term_i (last cycle of the phase)
module slot_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller feeding a 4:1 x 5-bit mux.
//   clk, rstn    : clock, asynchronous active-low reset
//   enable       : 1 = scan frames, 0 = idle with display dark
//   dig_en[3:0]  : per-digit anode mask, sampled every cycle
//   upd_valid    : producer offers upd_data
//   upd_data     : new digits, [4:0]=digit0 ... [19:15]=digit3
//   upd_ready    : combinational, high in IDLE and in the frame boundary cycle
//   sel          : mux select = current digit slot
//   d0..d3       : frame-coherent snapshot of digit data
//   an_n         : active-low anode enables (at most one bit low)
//   frame_start  : one-cycle pulse on the first DRIVE cycle of digit 0
//   dbg_state    : current scan FSM state
//
// Update handshake: a transfer happens on any rising edge where
// upd_valid && upd_ready. upd_ready never depends on upd_valid; a producer
// that sees no ready keeps valid and data stable until it does. Because ready
// is only high on the last cycle of a frame (or while idle), new digits always
// appear at the start of a frame, never mid-scan.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic [NUM_DIGITS-1:0]         dig_en,
  input  logic                          upd_valid,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] upd_data,
  output logic                          upd_ready,
  output logic [1:0]                    sel,
  output logic [DIGIT_W-1:0]            d0,
  output logic [DIGIT_W-1:0]            d1,
  output logic [DIGIT_W-1:0]            d2,
  output logic [DIGIT_W-1:0]            d3,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic                          frame_start,
  output logic [1:0]                    dbg_state
);

  localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);
  localparam logic [CNT_W-1:0] ON_TERM    = CNT_W'(ON_CYCLES - 1);
  // BLANK is never entered without blanking, so its terminal value is moot then.
  localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

  scan_state_e                   state_q;
  logic [1:0]                    sel_q;
  logic [NUM_DIGITS-1:0]         an_n_q;
  logic                          frame_start_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q;

  logic             tc;
  logic             timer_clr;
  logic [CNT_W-1:0] timer_term;
  logic [1:0]       sel_nxt;
  logic             frame_end;

  assign sel_nxt    = sel_q + 2'd1;
  assign timer_term = (state_q == BLANK) ? BLANK_TERM : ON_TERM;
  // Restart the count at every phase change and hold it at 0 while idle.
  assign timer_clr  = !enable || (state_q == IDLE) || tc;

  slot_timer #(
    .CNT_W (CNT_W)
  ) u_slot_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (timer_clr),
    .term_i (timer_term),
    .tc_o   (tc)
  );

  // Last cycle of slot 3: last BLANK cycle, or last DRIVE cycle without blanking.
  assign frame_end = tc && (sel_q == 2'd3) &&
                     (HAS_BLANK ? (state_q == BLANK) : (state_q == DRIVE));
  assign upd_ready = (state_q == IDLE) || frame_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      sel_q         <= 2'd0;
      an_n_q        <= '1;
      frame_start_q <= 1'b0;
      digits_q      <= '0;
    end else begin
      frame_start_q <= 1'b0;
      // Capture is independent of enable so a transfer in a disabling cycle completes.
      if (upd_valid && upd_ready) digits_q <= upd_data;

      if (!enable) begin
        state_q <= IDLE;
        sel_q   <= 2'd0;
        an_n_q  <= '1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q       <= DRIVE;
            sel_q         <= 2'd0;
            an_n_q        <= anode_pattern(2'd0, dig_en);
            frame_start_q <= 1'b1;
          end
          DRIVE: begin
            if (!tc) begin
              an_n_q <= anode_pattern(sel_q, dig_en);
            end else if (HAS_BLANK) begin
              state_q <= BLANK;
              an_n_q  <= '1;
            end else begin
              sel_q         <= sel_nxt;
              an_n_q        <= anode_pattern(sel_nxt, dig_en);
              frame_start_q <= (sel_q == 2'd3);
            end
          end
          BLANK: begin
            if (tc) begin
              state_q       <= DRIVE;
              sel_q         <= sel_nxt;
              an_n_q        <= anode_pattern(sel_nxt, dig_en);
              frame_start_q <= (sel_q == 2'd3);
            end
          end
          default: begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            an_n_q  <= '1;
          end
        endcase
      end
    end
  end

  assign sel         = sel_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;
  assign d0          = digits_q[0*DIGIT_W +: DIGIT_W];
  assign d1          = digits_q[1*DIGIT_W +: DIGIT_W];
  assign d2          = digits_q[2*DIGIT_W +: DIGIT_W];
  assign d3          = digits_q[3*DIGIT_W +: DIGIT_W];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: instance 0 with ON=4/BLANK=2 (24-cycle frame),
// instance 1 with ON=4/BLANK=0 (16-cycle frame). Both share enable/dig_en;
// only instance 0 receives digit updates.
module tb_disp_scan_ctrl;

  localparam int ON_C = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic [3:0]  dig_en = 4'hF;
  logic        upd_valid = 1'b0;
  logic [19:0] upd_data = '0;
  logic        upd_valid_b = 1'b0;
  logic [19:0] upd_data_b = '0;

  logic        upd_ready_w [2];
  logic [1:0]  sel_w [2];
  logic [4:0]  d0_w [2];
  logic [4:0]  d1_w [2];
  logic [4:0]  d2_w [2];
  logic [4:0]  d3_w [2];
  logic [3:0]  an_n_w [2];
  logic        fs_w [2];
  logic [1:0]  st_w [2];

  disp_scan_ctrl #(.ON_CYCLES(ON_C), .BLANK_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rstn(rstn), .enable(enable), .dig_en(dig_en),
    .upd_valid(upd_valid), .upd_data(upd_data), .upd_ready(upd_ready_w[0]),
    .sel(sel_w[0]), .d0(d0_w[0]), .d1(d1_w[0]), .d2(d2_w[0]), .d3(d3_w[0]),
    .an_n(an_n_w[0]), .frame_start(fs_w[0]), .dbg_state(st_w[0])
  );

  disp_scan_ctrl #(.ON_CYCLES(ON_C), .BLANK_CYCLES(0), .CNT_W(16)) dut_b (
    .clk(clk), .rstn(rstn), .enable(enable), .dig_en(dig_en),
    .upd_valid(upd_valid_b), .upd_data(upd_data_b), .upd_ready(upd_ready_w[1]),
    .sel(sel_w[1]), .d0(d0_w[1]), .d1(d1_w[1]), .d2(d2_w[1]), .d3(d3_w[1]),
    .an_n(an_n_w[1]), .frame_start(fs_w[1]), .dbg_state(st_w[1])
  );

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  int total = 0;
  int bad = 0;
  bit done = 1'b0;
  bit xfer_next = 1'b0;

  function automatic void chk(input string name, input int idx,
                              input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t: got %0h want %0h", name, idx, $time, got, want);
    end
  endfunction

  // Reference model: position in the frame is just cycles since the scan began.
  task automatic monitor(input int idx, input int on_c, input int bl_c);
    int slot_len;
    int frame_len;
    bit run;
    int t;
    int slot;
    int ph;
    logic [19:0] mdig;
    logic        en_s;
    logic [3:0]  mask_s;
    logic        vld_s;
    logic        rdy_m;
    logic [3:0]  an_e;
    logic [3:0]  one_hot;
    logic [1:0]  sel_e;
    logic        fs_e;
    slot_len  = on_c + bl_c;
    frame_len = 4 * slot_len;
    run  = 1'b0;
    t    = 0;
    mdig = '0;
    while (!done) begin
      @(negedge clk);
      #3;
      en_s   = enable;
      mask_s = dig_en;
      vld_s  = (idx == 0) ? upd_valid : upd_valid_b;
      rdy_m  = !run || ((t % frame_len) == frame_len - 1);
      chk("upd_ready", idx, 32'(upd_ready_w[idx]), 32'(rdy_m));
      if (vld_s && rdy_m) begin
        if (idx == 0 && exp_q.size() > 0) begin
          mdig = exp_q.pop_front();
        end else begin
          total++;
          bad++;
          $display("FAIL xfer_without_expect inst%0d t=%0t: got transfer want none", idx, $time);
        end
      end
      if (!en_s) begin
        run = 1'b0;
        t   = 0;
      end else if (!run) begin
        run = 1'b1;
        t   = 0;
      end else begin
        t++;
      end
      @(posedge clk);
      #1;
      if (run) begin
        slot    = (t / slot_len) % 4;
        ph      = t % slot_len;
        one_hot = 4'b0001 << slot;
        an_e    = (ph < on_c && mask_s[slot]) ? ~one_hot : 4'hF;
        sel_e   = 2'(slot);
        fs_e    = ((t % frame_len) == 0);
      end else begin
        an_e  = 4'hF;
        sel_e = 2'd0;
        fs_e  = 1'b0;
      end
      chk("an_n", idx, 32'(an_n_w[idx]), 32'(an_e));
      chk("sel", idx, 32'(sel_w[idx]), 32'(sel_e));
      chk("frame_start", idx, 32'(fs_w[idx]), 32'(fs_e));
      chk("digits", idx, 32'({d3_w[idx], d2_w[idx], d1_w[idx], d0_w[idx]}), 32'(mdig));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n cycles, releasing upd_valid once its transfer edge has passed.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (xfer_next) begin
        upd_valid = 1'b0;
        xfer_next = 1'b0;
      end
      if (upd_valid && upd_ready_w[0]) xfer_next = 1'b1;
    end
  endtask

  task automatic send(input logic [19:0] data);
    if (!upd_valid) begin
      upd_data  = data;
      upd_valid = 1'b1;
      exp_q.push_back(data);
      if (upd_ready_w[0]) xfer_next = 1'b1;
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_an_n", i, 32'(an_n_w[i]), 32'h0000000F);
      chk("rst_sel", i, 32'(sel_w[i]), 32'h0);
      chk("rst_digits", i, 32'({d3_w[i], d2_w[i], d1_w[i], d0_w[i]}), 32'h0);
      chk("rst_upd_ready", i, 32'(upd_ready_w[i]), 32'h1);
      chk("rst_frame_start", i, 32'(fs_w[i]), 32'h0);
    end
    rstn = 1'b1;
    fork
      monitor(0, ON_C, 2);
      monitor(1, ON_C, 0);
    join_none

    // idle with enable low
    cyc(10);

    // full-mask scan, update mid-frame
    enable = 1'b1;
    cyc(30);
    send(20'h8C631);
    cyc(30);

    // masked frames
    dig_en = 4'b0101;
    cyc(48);
    dig_en = 4'hF;

    // disable in slot 2 DRIVE, then re-enable
    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    cyc(14);
    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    cyc(30);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cyc(1);
      if ($urandom_range(0, 19) == 0) dig_en = 4'($urandom_range(0, 15));
      if (enable) begin
        if ($urandom_range(0, 149) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        enable = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) send(20'($urandom));
    end

    // drain any pending update
    enable = 1'b1;
    for (int i = 0; i < 60 && upd_valid; i++) cyc(1);
    cyc(2);
    done = 1'b1;
    repeat (3) @(negedge clk);
    chk("exp_q_empty", 0, 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
